// File: rtl/fb_rect_filler_if.sv
// Command and framebuffer-write bus for fb_rect_filler.
//   cmd_*  : one rectangle-fill command (valid/ready handshake)
//   wr_*   : per-pixel framebuffer write port with backpressure (wr_ready)
//   busy   : a command is in progress
//   done   : one-cycle pulse when a command completes
// The slave modport is the filler's view. The master modport is the view of
// the command source and framebuffer.
interface fb_rect_filler_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned COLOR_W = 8
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [COORD_W-1:0]     cmd_x0;
  logic [COORD_W-1:0]     cmd_y0;
  logic [COORD_W:0]       cmd_w;
  logic [COORD_W:0]       cmd_h;
  logic [COLOR_W-1:0]     cmd_color;
  logic                   wr_en;
  logic [2*COORD_W-1:0]   wr_addr;
  logic [COLOR_W-1:0]     wr_data;
  logic                   wr_ready;
  logic                   busy;
  logic                   done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, wr_ready,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, wr_ready,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/fb_rect_filler.sv
// Rectangle-fill sequencer for a 2^COORD_W x 2^COORD_W framebuffer.
// The block accepts one fill command and then emits one write per visible
// pixel in row-major order. Pixels that fall off the screen are clipped.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : fb_rect_filler_if.slave (command handshake, write port, busy/done)
module fb_rect_filler #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned COLOR_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  fb_rect_filler_if.slave bus
);
  localparam int unsigned EW = COORD_W + 1;
  localparam logic [EW-1:0] SCREEN = EW'(2 ** COORD_W);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t               r_state, w_state_n;
  logic [EW-1:0]        r_cur_x, r_cur_y, r_x0, r_x_end, r_y_end;
  logic [EW-1:0]        w_cur_x_n, w_cur_y_n, w_x0_n, w_x_end_n, w_y_end_n;
  logic [COLOR_W-1:0]   r_color, w_color_n;
  logic                 r_cmd_ready, r_wr_en, r_busy, r_done;

  logic [EW-1:0]        w_x0, w_y0, w_room_x, w_room_y, w_ew, w_eh;
  logic [EW-1:0]        w_x_inc, w_y_inc;
  logic                 w_xfer;

  // The clip arithmetic uses COORD_W+1 bits, so an origin of 15 still
  // leaves room for a width of 1, and 16 - x0 never wraps.
  assign w_x0     = {1'b0, bus.cmd_x0};
  assign w_y0     = {1'b0, bus.cmd_y0};
  assign w_room_x = SCREEN - w_x0;
  assign w_room_y = SCREEN - w_y0;
  assign w_ew     = (bus.cmd_w < w_room_x) ? bus.cmd_w : w_room_x;
  assign w_eh     = (bus.cmd_h < w_room_y) ? bus.cmd_h : w_room_y;
  assign w_x_inc  = r_cur_x + EW'(1);
  assign w_y_inc  = r_cur_y + EW'(1);
  assign w_xfer   = r_wr_en && bus.wr_ready;

  always_comb begin
    w_state_n = r_state;
    w_cur_x_n = r_cur_x;
    w_cur_y_n = r_cur_y;
    w_x0_n    = r_x0;
    w_x_end_n = r_x_end;
    w_y_end_n = r_y_end;
    w_color_n = r_color;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_x0_n    = w_x0;
          w_x_end_n = w_x0 + w_ew;
          w_y_end_n = w_y0 + w_eh;
          w_color_n = bus.cmd_color;
          w_cur_x_n = w_x0;
          w_cur_y_n = w_y0;
          w_state_n = (w_ew == '0 || w_eh == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_xfer) begin
          if (w_x_inc < r_x_end) begin
            w_cur_x_n = w_x_inc;
          end else begin
            w_cur_x_n = r_x0;
            if (w_y_inc == r_y_end) w_state_n = S_DONE;
            else                    w_cur_y_n = w_y_inc;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // The handshake and status outputs are registered from the next state, so
  // they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_x0        <= '0;
      r_x_end     <= '0;
      r_y_end     <= '0;
      r_color     <= '0;
      r_cmd_ready <= 1'b1;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cur_x     <= w_cur_x_n;
      r_cur_y     <= w_cur_y_n;
      r_x0        <= w_x0_n;
      r_x_end     <= w_x_end_n;
      r_y_end     <= w_y_end_n;
      r_color     <= w_color_n;
      r_cmd_ready <= (w_state_n == S_IDLE);
      r_wr_en     <= (w_state_n == S_FILL);
      r_busy      <= (w_state_n != S_IDLE);
      r_done      <= (w_state_n == S_DONE);
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = {r_cur_y[COORD_W-1:0], r_cur_x[COORD_W-1:0]};
  assign bus.wr_data   = r_color;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: doc/fb_rect_filler.md
# fb_rect_filler

Rectangle-fill sequencer for the 16x16, 8-bit-per-pixel pixel framebuffer. It accepts one fill command (origin, width, height, color) over a valid/ready handshake and emits one framebuffer write per pixel, in row-major order, over a write port with backpressure. Pixels outside the 16x16 area are clipped and never written. It sits between the GPU command decoder and the framebuffer write port, replacing per-pixel draw sequences for block fills.

## Interface
- COORD_W, 4: coordinate width; the screen is 2^COORD_W x 2^COORD_W pixels.
- COLOR_W, 8: pixel/color width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_x0, cmd_y0  in  COORD_W each  rectangle origin.
- cmd_w, cmd_h  in  COORD_W+1 each  width/height in pixels, 0..16.
- cmd_color  in  COLOR_W  fill color.
- wr_en  out  1  write request to framebuffer.
- wr_addr  out  2*COORD_W  pixel address = {y, x}, i.e. y*16 + x.
- wr_data  out  COLOR_W  pixel value.
- wr_ready  in  1  framebuffer accepts the write this cycle.
- busy  out  1  high in FILL and DONE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, FILL, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch x0, y0, color and the clipped extents: ew = min(cmd_w, 16-x0), eh = min(cmd_h, 16-y0), computed in COORD_W+1-bit arithmetic with no wrap. If ew==0 or eh==0, go to DONE; otherwise go to FILL with cur_x=x0, cur_y=y0.
- FILL: wr_en=1, wr_addr={cur_y[COORD_W-1:0], cur_x[COORD_W-1:0]}, wr_data=latched color.
  - A transfer occurs on wr_en&&wr_ready.
  - While wr_ready=0, wr_addr and wr_data hold stable and the counters do not advance.
  - On a transfer, x advances first. If cur_x+1 < x0+ew, cur_x increments. Otherwise cur_x returns to x0 and cur_y increments.
  - On the transfer of the last pixel (cur_x = x0+ew-1 and cur_y = y0+eh-1), go to DONE.
- DONE: done=1 and wr_en=0 for exactly one cycle, then IDLE.
- cmd_valid is ignored while cmd_ready=0. Command fields are sampled only at acceptance; later changes have no effect.
- Clipped pixels produce no write request and cost no cycles.
- Reset: state=IDLE, cmd_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, and the internal counters are cleared.
  - Reset asserted mid-FILL aborts the command at that edge. No further writes occur and no done pulse is produced.
  - Writes already transferred are not undone.

## Timing
- Command accepted at edge T. The first wr_en is visible in the cycle after T.
- With wr_ready held at 1, the N = ew*eh pixels transfer on N consecutive cycles. done is high in the cycle after the last transfer, and cmd_ready returns high one cycle after that. Throughput is N+2 cycles per command.
- Each cycle with wr_en=1 and wr_ready=0 adds exactly one cycle of latency.
- Empty or fully clipped command: done is high in the cycle after acceptance.
- done and cmd_ready are never high in the same cycle. wr_en and done are never high in the same cycle.
- Outputs are registered. The only combinational dependency is the transfer condition wr_en&&wr_ready.

## Test plan
- Basic 2x2 fill: x0=3, y0=5, w=2, h=2, color=0xA5, wr_ready=1 -> writes to addresses 0x53, 0x54, 0x63, 0x64, all with data 0xA5, on 4 consecutive cycles. done is high in the next cycle, and cmd_ready is high in the one after.
- Clipping: x0=14, y0=15, w=4, h=3, color=0x11 -> exactly 2 writes, to 0xFE and 0xFF, then done. No address wraps to row 0 or column 0.
- Backpressure: x0=0, y0=0, w=3, h=1, with wr_ready low on every second cycle -> addresses 0x00, 0x01, 0x02 transfer in order. wr_addr/wr_data hold stable during stalls, and done arrives 3 + (stall count) + 1 cycles after acceptance.
- Empty and full commands: w=0, h=7 -> no wr_en, done in the cycle after acceptance. Then x0=0, y0=0, w=16, h=16 -> 256 writes covering 0x00..0xFF, with done in cycle 257.
- Handshake: cmd_valid held high with changing fields during FILL -> no second acceptance and no change to the written color. A back-to-back command is accepted only in the cycle when cmd_ready=1.
- Reset mid-fill: 4x4 fill, reset driven low after 5 transfers -> wr_en=0 and cmd_ready=1 from the next cycle, no done pulse. A new command issued after reset is released executes normally.
